// File: rtl/xform_sched_pkg.sv
// Shared types and default widths for the shared-transform scheduler.
package xform_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  localparam int XF_IN_W  = 9;
  localparam int XF_OUT_W = 4;
  localparam int CNT_W    = 16;

endpackage

// File: rtl/xform_share_sched_rr_arbiter.sv
// Round-robin pick: first asserted request strictly after 'last', wrapping.
// Purely combinational; no state, no backpressure of its own.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    // Scan offsets 1..N so 'last' itself has lowest priority.
    for (int k = 1; k <= N; k++) begin
      if (!any && req[(int'(last) + k) % N]) begin
        any                                 = 1'b1;
        gnt_id                              = ID_W'((int'(last) + k) % N);
        gnt_onehot[(int'(last) + k) % N]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xform_share_sched.sv
// Shares one combinational transform among NUM_REQ requesters, round-robin, 2 cycles accept->resp.
// A pending response blocks new grants until resp_ready; a grant can ride the response handshake.
module xform_share_sched
  import xform_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int IN_W    = XF_IN_W,
  parameter  int OUT_W   = XF_OUT_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         xf_in,
  input  logic [OUT_W-1:0]        xf_out,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [OUT_W-1:0]        resp_data,
  input  logic                    resp_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_count
);

  sched_state_e       state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [IN_W-1:0]    op_q, op_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  logic [OUT_W-1:0]   resp_data_q, resp_data_d;
  logic [CNT_W-1:0]   done_count_q, done_count_d;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [ID_W-1:0]    arb_id;
  logic               arb_any;
  logic               resp_hs;
  logic               accept;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last       (last_grant_q),
    .gnt_onehot (arb_onehot),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    done_count_d = done_count_q;
    req_ready    = '0;

    resp_hs = (state_q == RESP) && resp_ready;
    accept  = arb_any && ((state_q == IDLE) || resp_hs);

    case (state_q)
      IDLE: begin
        if (accept) state_d = EXEC;
      end
      EXEC: begin
        resp_data_d  = xf_out;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // Valid drops on every handshake so a back-to-back EXEC never shows a stale result.
        if (resp_hs) begin
          done_count_d = done_count_q + CNT_W'(1);
          resp_valid_d = 1'b0;
          state_d      = accept ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      req_ready    = arb_onehot;
      op_d         = req_data[arb_id*IN_W +: IN_W];
      id_d         = arb_id;
      last_grant_d = arb_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_q         <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      done_count_q <= done_count_d;
    end
  end

  assign xf_in      = op_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);
  assign done_count = done_count_q;

endmodule

// File: tb/tb_xform_share_sched.sv
// Bench for xform_share_sched with a loopback transform (xf_out = xf_in[3:0]).
module tb_xform_share_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rv;
  logic [35:0] rd;
  logic [3:0]  req_ready;
  logic [8:0]  xf_in;
  logic [3:0]  xf_out;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [3:0]  resp_data;
  logic        rr;
  logic        busy;
  logic [15:0] done_count;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_on;
  logic [15:0] cnt_off;

  int gid_q[$];
  int gcy_q[$];
  int rid_q[$];
  int rdat_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign xf_out = xf_in[3:0];

  xform_share_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (rv),
    .req_data   (rd),
    .req_ready  (req_ready),
    .xf_in      (xf_in),
    .xf_out     (xf_out),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (rr),
    .busy       (busy),
    .done_count (done_count)
  );

  // Transaction-level model: an operand slot being transformed, one result slot, a grant pointer.
  function automatic logic [2:0] pick(input logic [3:0] v, input logic [1:0] last);
    logic [2:0] r;
    logic [1:0] i;
    r = 3'b0;
    for (int k = 1; k <= 4; k++) begin
      i = last + 2'(k);
      if (!r[2] && v[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  function automatic logic [3:0] xf(input logic [8:0] v);
    return v[3:0];
  endfunction

  logic        m_ex_vld, m_res_vld;
  logic [1:0]  m_ex_id, m_res_id, m_last;
  logic [8:0]  m_op;
  logic [3:0]  m_res_data;
  logic [15:0] m_hs;
  logic [2:0]  m_pick;
  logic        m_acc;

  assign m_pick = pick(rv, m_last);
  assign m_acc  = !m_ex_vld && (!m_res_vld || rr) && m_pick[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex_vld   <= 1'b0;
      m_res_vld  <= 1'b0;
      m_ex_id    <= 2'd0;
      m_res_id   <= 2'd0;
      m_res_data <= 4'd0;
      m_last     <= 2'd3;
      m_op       <= 9'd0;
      m_hs       <= 16'd0;
    end else begin
      if (m_res_vld && rr) begin
        m_res_vld <= 1'b0;
        m_hs      <= m_hs + 16'd1;
      end
      if (m_ex_vld) begin
        m_res_vld  <= 1'b1;
        m_res_id   <= m_ex_id;
        m_res_data <= xf(m_op);
        m_ex_vld   <= 1'b0;
      end
      if (m_acc) begin
        m_ex_vld <= 1'b1;
        m_ex_id  <= m_pick[1:0];
        m_op     <= rd[m_pick[1:0]*9 +: 9];
        m_last   <= m_pick[1:0];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    chk("m_req_ready", 32'(req_ready), m_acc ? 32'(4'b0001 << m_pick[1:0]) : 32'd0);
    chk("m_xf_in", 32'(xf_in), 32'(m_op));
    chk("m_resp_valid", 32'(resp_valid), 32'(m_res_vld));
    chk("m_resp_id", 32'(resp_id), 32'(m_res_id));
    chk("m_resp_data", 32'(resp_data), 32'(m_res_data));
    chk("m_busy", 32'(busy), 32'(m_ex_vld || m_res_vld));
    chk("m_done_count", 32'(done_count), 32'(16'(m_hs + cnt_off)));
  endtask

  task automatic monitor();
    for (int i = 0; i < 4; i++) begin
      if (req_ready[i]) begin
        gid_q.push_back(i);
        gcy_q.push_back(cyc);
      end
    end
    if (resp_valid && rr) begin
      rid_q.push_back(int'(resp_id));
      rdat_q.push_back(int'(resp_data));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q0, r0;
    int exp_seq[5];
    rst_n = 1'b1; rv = '0; rd = '0; rr = 1'b1; cnt_off = '0; chk_on = 1'b0;
    fork
      forever begin
        @(negedge clk);
        if (chk_on) begin
          model_compare();
          monitor();
        end
      end
    join_none
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_xf_in", 32'(xf_in), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);

    // Single request from requester 2
    step();
    rv = 4'b0100; rd[18 +: 9] = 9'h1A5;
    @(negedge clk); chk("t1_req_ready", 32'(req_ready), 32'h4);
    step(); rv = '0;
    @(negedge clk);
    chk("t1_exec_busy", 32'(busy), 32'd1);
    chk("t1_exec_xf_in", 32'(xf_in), 32'h1A5);
    chk("t1_exec_rv", 32'(resp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t1_resp_valid", 32'(resp_valid), 32'd1);
    chk("t1_resp_id", 32'(resp_id), 32'd2);
    chk("t1_resp_data", 32'(resp_data), 32'h5);
    step();
    @(negedge clk);
    chk("t1_done", 32'(done_count), 32'd1);
    chk("t1_idle_rv", 32'(resp_valid), 32'd0);

    // All four requesting after a fresh reset: 0,1,2,3,0 every 2 cycles
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) rd[i*9 +: 9] = 9'(9'h100 + i);
    q0 = gid_q.size(); r0 = rid_q.size();
    rv = 4'hF;
    repeat (9) @(posedge clk);
    #1 rv = '0;
    repeat (3) step();
    exp_seq = '{0, 1, 2, 3, 0};
    chk("t2_grant_cnt", 32'(gid_q.size() - q0), 32'd5);
    chk("t2_resp_cnt", 32'(rid_q.size() - r0), 32'd5);
    if (gid_q.size() - q0 >= 5 && rid_q.size() - r0 >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("t2_grant_id", 32'(gid_q[q0+i]), 32'(exp_seq[i]));
        chk("t2_resp_id", 32'(rid_q[r0+i]), 32'(exp_seq[i]));
        chk("t2_resp_data", 32'(rdat_q[r0+i]), 32'(exp_seq[i]));
        if (i > 0) chk("t2_grant_gap", 32'(gcy_q[q0+i] - gcy_q[q0+i-1]), 32'd2);
      end
    end

    // Backpressure: hold 5 cycles, next grant rides the handshake
    rd[9 +: 9] = 9'h0B7; rd[18 +: 9] = 9'h1C3;
    rv = 4'b0110; rr = 1'b0;
    @(negedge clk); chk("t3_first_grant", 32'(req_ready), 32'h2);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(resp_valid), 32'd1);
      chk("t3_hold_id", 32'(resp_id), 32'd1);
      chk("t3_hold_data", 32'(resp_data), 32'h7);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    rr = 1'b1;
    @(negedge clk);
    chk("t3_hs_grant", 32'(req_ready), 32'h4);
    chk("t3_hs_valid", 32'(resp_valid), 32'd1);
    step(); rv = '0;
    repeat (3) step();

    // Skipping: last_grant=1 with only 1 and 3 requesting
    rd[27 +: 9] = 9'h0EC;
    rv = 4'b0010;
    step(); rv = '0;
    repeat (3) step();
    rv = 4'b1010;
    @(negedge clk); chk("t4_grant3", 32'(req_ready), 32'h8);
    step(); step();
    @(negedge clk);
    chk("t4_grant1", 32'(req_ready), 32'h2);
    chk("t4_resp_data3", 32'(resp_data), 32'hC);
    step(); rv = '0;
    repeat (3) step();

    // Reset while in EXEC
    rv = 4'b0100;
    step(); rv = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", 32'(resp_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done_count), 32'd0);
    step(); rst_n = 1'b1; rv = 4'hF;
    @(negedge clk); chk("t5_grant0", 32'(req_ready), 32'h1);
    step(); rv = '0;
    repeat (3) step();

    // Counter wrap via preload
    #1;
    dut.done_count_q = 16'hFFFF;
    cnt_off = 16'hFFFF - m_hs;
    @(negedge clk); chk("t6_preload", 32'(done_count), 32'hFFFF);
    step(); rv = 4'b0001;
    step(); rv = '0;
    repeat (3) step();
    @(negedge clk); chk("t6_wrap", 32'(done_count), 32'd0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
